// File: rtl/mips_imem_pkg.sv
// mips_imem_pkg: shared types and constants for the
// instruction-memory sequencer (FSM states, NOP word, counter widths).
package mips_imem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam int          LOOPCNT_W = 8;
    localparam int          WAITCNT_W = 3;

    // Terminal value of the wait counter for a given wait length.
    function automatic logic [WAITCNT_W-1:0] wait_last(input int w);
        return (w == 0) ? '0 : WAITCNT_W'(w - 1);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// imem_ram: DEPTH x DATA_W program store, one synchronous write
// port and one asynchronous read port (read returns pre-write data).
// Ports: clk_i, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read).
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_imem_sequencer.sv
// mips_imem_sequencer: feeds program words to the MIPS core fetch bus,
// sourced from an internal counter (stream) or from PCF (address mode).
// Ports: CLK/RST, LoadEn/LoadAddr/LoadData (program load),
// Start/AddrMode/ProgLen (run control), PCF/Stall (core fetch side),
// IM_RD/InstrValid/Done/LoopCnt (registered outputs).
module mips_imem_sequencer
    import mips_imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WAIT_W = 0,
    parameter int LOOP   = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 LoadEn,
    input  logic [ADDR_W-1:0]    LoadAddr,
    input  logic [DATA_W-1:0]    LoadData,
    input  logic                 Start,
    input  logic                 AddrMode,
    input  logic [ADDR_W:0]      ProgLen,
    input  logic [31:0]          PCF,
    input  logic                 Stall,
    output logic [DATA_W-1:0]    IM_RD,
    output logic                 InstrValid,
    output logic                 Done,
    output logic [LOOPCNT_W-1:0] LoopCnt
);

    localparam logic [ADDR_W:0]    DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [DATA_W-1:0]  NOP_D    = DATA_W'(NOP_WORD);
    localparam logic [WAITCNT_W-1:0] WAIT_END = wait_last(WAIT_W);

    seq_state_t           state_q;
    logic [ADDR_W-1:0]    idx_q;
    logic [ADDR_W:0]      wcnt_q;
    logic [ADDR_W:0]      len_q;
    logic [WAITCNT_W-1:0] wait_q;
    logic                 mode_q;
    logic                 fin_q;
    logic [DATA_W-1:0]    rd_q;
    logic                 valid_q;
    logic                 done_q;
    logic [LOOPCNT_W-1:0] loop_q;

    logic [ADDR_W-1:0]    pc_idx;
    logic [ADDR_W-1:0]    rd_idx_d;
    logic [DATA_W-1:0]    ram_rd;
    logic [DATA_W-1:0]    word_d;
    logic [ADDR_W:0]      len_d;
    logic                 oob_d;
    logic                 last_d;
    logic                 unused_pcf;

    assign pc_idx     = PCF[ADDR_W+1:2];
    assign unused_pcf = ^{PCF[31:ADDR_W+2], PCF[1:0]};
    assign rd_idx_d   = mode_q ? pc_idx : idx_q;

    // Address mode ends on the first fetch past the program; that
    // fetch gets a NOP rather than whatever sits in the array.
    assign oob_d  = mode_q && ({1'b0, pc_idx} >= len_q);
    assign last_d = mode_q ? oob_d : (wcnt_q == len_q - 1'b1);
    assign word_d = oob_d ? NOP_D : ram_rd;
    assign len_d  = (ProgLen > DEPTH_L) ? DEPTH_L : ProgLen;

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (LoadEn),
        .waddr_i (LoadAddr),
        .wdata_i (LoadData),
        .raddr_i (rd_idx_d),
        .rdata_o (ram_rd)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
            len_q   <= '0;
            wait_q  <= '0;
            mode_q  <= 1'b0;
            fin_q   <= 1'b0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            loop_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (state_q == S_DONE) begin
                        rd_q    <= NOP_D;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    if (Start) begin
                        mode_q  <= AddrMode;
                        len_q   <= len_d;
                        idx_q   <= '0;
                        wcnt_q  <= '0;
                        wait_q  <= '0;
                        fin_q   <= 1'b0;
                        rd_q    <= NOP_D;
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= (len_d == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!Stall) begin
                        rd_q    <= word_d;
                        valid_q <= 1'b1;
                        if (last_d && (LOOP != 0)) begin
                            idx_q  <= '0;
                            wcnt_q <= '0;
                            loop_q <= loop_q + 1'b1;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                            if (!mode_q) begin
                                idx_q <= idx_q + 1'b1;
                            end
                            if (last_d) begin
                                fin_q <= 1'b1;
                            end
                        end
                        // Finishing with no wait goes straight to DONE;
                        // otherwise WAIT decides via fin_q.
                        if (WAIT_W > 0) begin
                            wait_q  <= '0;
                            state_q <= S_WAIT;
                        end else if (last_d && (LOOP == 0)) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    valid_q <= 1'b0;
                    if (wait_q == WAIT_END) begin
                        wait_q  <= '0;
                        state_q <= fin_q ? S_DONE : S_RUN;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign IM_RD      = rd_q;
    assign InstrValid = valid_q;
    assign Done       = done_q;
    assign LoopCnt    = loop_q;

endmodule

// File: tb/tb_mips_imem_sequencer.sv
// tb_mips_imem_sequencer: three sequencer configurations driven in
// parallel and checked each cycle against a behavioural model.
module tb_mips_imem_sequencer;

    localparam int DW = 32;
    localparam int DEP = 16;
    localparam int AW = 4;
    localparam int P_IDLE = 0;
    localparam int P_RUN = 1;
    localparam int P_WAIT = 2;
    localparam int P_DONE = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic LoadEn = 1'b0;
    logic Start = 1'b0;
    logic AddrMode = 1'b0;
    logic Stall = 1'b0;
    logic [AW-1:0] LoadAddr = '0;
    logic [DW-1:0] LoadData = '0;
    logic [AW:0] ProgLen = '0;
    logic [31:0] PCF = '0;

    logic [2:0][DW-1:0] rd_a;
    logic [2:0] v_a;
    logic [2:0] d_a;
    logic [2:0][7:0] lc_a;

    int n_pass = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    mips_imem_sequencer #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW),
                          .WAIT_W(0), .LOOP(0)) u0 (
        .CLK(CLK), .RST(RST), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
        .LoadData(LoadData), .Start(Start), .AddrMode(AddrMode),
        .ProgLen(ProgLen), .PCF(PCF), .Stall(Stall),
        .IM_RD(rd_a[0]), .InstrValid(v_a[0]), .Done(d_a[0]),
        .LoopCnt(lc_a[0]));

    mips_imem_sequencer #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW),
                          .WAIT_W(2), .LOOP(0)) u1 (
        .CLK(CLK), .RST(RST), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
        .LoadData(LoadData), .Start(Start), .AddrMode(AddrMode),
        .ProgLen(ProgLen), .PCF(PCF), .Stall(Stall),
        .IM_RD(rd_a[1]), .InstrValid(v_a[1]), .Done(d_a[1]),
        .LoopCnt(lc_a[1]));

    mips_imem_sequencer #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW),
                          .WAIT_W(0), .LOOP(1)) u2 (
        .CLK(CLK), .RST(RST), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
        .LoadData(LoadData), .Start(Start), .AddrMode(AddrMode),
        .ProgLen(ProgLen), .PCF(PCF), .Stall(Stall),
        .IM_RD(rd_a[2]), .InstrValid(v_a[2]), .Done(d_a[2]),
        .LoopCnt(lc_a[2]));

    function automatic int waits(input int i);
        return (i == 1) ? 2 : 0;
    endfunction

    function automatic bit loops(input int i);
        return (i == 2);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: per-instance phase plus a program position.
    logic [31:0] mm [DEP];
    int ph [3];
    int wl [3];
    int pos [3];
    int mlen [3];
    bit mmode [3];
    bit fin [3];
    logic [31:0] e_rd [3];
    bit e_v [3];
    bit e_d [3];
    logic [7:0] e_lc [3];

    task automatic mreset();
        for (int i = 0; i < 3; i++) begin
            ph[i] = P_IDLE; wl[i] = 0; pos[i] = 0; mlen[i] = 0;
            mmode[i] = 0; fin[i] = 0;
            e_rd[i] = '0; e_v[i] = 0; e_d[i] = 0; e_lc[i] = '0;
        end
    endtask

    task automatic mstep();
        int k;
        int plen;
        plen = (int'(ProgLen) > DEP) ? DEP : int'(ProgLen);
        k = int'(PCF[5:2]);
        for (int i = 0; i < 3; i++) begin
            if (ph[i] == P_RUN) begin
                if (!Stall) begin
                    bit last;
                    if (mmode[i]) begin
                        last = (k >= mlen[i]);
                        e_rd[i] = last ? 32'h0 : mm[k];
                    end else begin
                        last = (pos[i] == mlen[i] - 1);
                        e_rd[i] = mm[pos[i]];
                        pos[i]++;
                    end
                    e_v[i] = 1;
                    if (last && loops(i)) begin
                        pos[i] = 0;
                        e_lc[i] = e_lc[i] + 8'd1;
                    end else if (last) begin
                        fin[i] = 1;
                    end
                    if (waits(i) > 0) begin
                        ph[i] = P_WAIT;
                        wl[i] = waits(i);
                    end else if (fin[i]) begin
                        ph[i] = P_DONE;
                    end
                end
            end else if (ph[i] == P_WAIT) begin
                e_v[i] = 0;
                wl[i]--;
                if (wl[i] == 0) ph[i] = fin[i] ? P_DONE : P_RUN;
            end else begin
                if (ph[i] == P_DONE) begin
                    e_rd[i] = '0; e_v[i] = 0; e_d[i] = 1;
                end
                if (Start) begin
                    mmode[i] = AddrMode; mlen[i] = plen;
                    pos[i] = 0; fin[i] = 0;
                    e_rd[i] = '0; e_v[i] = 0; e_d[i] = 0;
                    ph[i] = (plen == 0) ? P_DONE : P_RUN;
                end
            end
        end
        if (LoadEn) mm[LoadAddr] = LoadData;
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) mreset();
            else mstep();
            @(negedge CLK);
            for (int i = 0; i < 3; i++)
                chk($sformatf("u%0d_cyc", i),
                    {rd_a[i], 3'b0, v_a[i], 3'b0, d_a[i], lc_a[i]},
                    {e_rd[i], 3'b0, e_v[i], 3'b0, e_d[i], e_lc[i]});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            chk("rst_clear", {rd_a[i], v_a[i], d_a[i], lc_a[i]}, 64'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic go(input logic m, input int len);
        AddrMode = m;
        ProgLen = (AW + 1)'(len);
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        tick(2);
        RST = 1'b0;
        chk("reset_u0", {rd_a[0], v_a[0], d_a[0], lc_a[0]}, 64'd0);

        for (int a = 0; a < DEP; a++) begin
            LoadEn = 1'b1;
            LoadAddr = AW'(a);
            LoadData = (a < 11) ? 32'h2008_0001 + 32'(a) : $urandom;
            tick();
        end
        LoadEn = 1'b0;

        // stream, 11 words back to back
        do_reset();
        go(0, 11);
        chk("t1_pre", {63'd0, v_a[0]}, 64'd0);
        for (int k = 0; k < 11; k++) begin
            tick();
            chk("t1_word", {v_a[0], rd_a[0]}, {1'b1, 32'h2008_0001 + 32'(k)});
        end
        tick();
        chk("t1_done", {d_a[0], v_a[0], rd_a[0]}, {1'b1, 1'b0, 32'h0});

        // stall for 3 cycles after word 4
        do_reset();
        go(0, 11);
        tick(4);
        chk("t2_w4", {v_a[0], rd_a[0]}, {1'b1, 32'h2008_0004});
        Stall = 1'b1;
        repeat (3) begin
            tick();
            chk("t2_hold", {v_a[0], rd_a[0]}, {1'b1, 32'h2008_0004});
        end
        Stall = 1'b0;
        for (int k = 4; k < 11; k++) begin
            tick();
            chk("t2_word", {v_a[0], rd_a[0]}, {1'b1, 32'h2008_0001 + 32'(k)});
        end
        tick();
        chk("t2_done", {d_a[0], rd_a[0]}, {1'b1, 32'h0});

        // two wait states, three words
        do_reset();
        go(0, 3);
        for (int j = 0; j < 9; j++) begin
            tick();
            chk("t3_valid", {63'd0, v_a[1]}, {63'd0, (j % 3) == 0});
        end
        tick();
        chk("t3_done", {63'd0, d_a[1]}, 64'd1);

        // address mode, PCF 0,8,4,0x10
        do_reset();
        go(1, 4);
        PCF = 32'h0;
        tick();
        chk("t4_pc0", rd_a[0], 32'h2008_0001);
        PCF = 32'h8;
        tick();
        chk("t4_pc8", rd_a[0], 32'h2008_0003);
        PCF = 32'h4;
        tick();
        chk("t4_pc4", rd_a[0], 32'h2008_0002);
        PCF = 32'h10;
        tick();
        chk("t4_nop", {v_a[0], rd_a[0]}, {1'b1, 32'h0});
        PCF = 32'h0;
        tick();
        chk("t4_done", {63'd0, d_a[0]}, 64'd1);

        // loop mode, two words
        do_reset();
        go(0, 2);
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("t5_loop", {rd_a[2], lc_a[2], d_a[2]},
                {32'h2008_0001 + 32'(j % 2), 8'((j + 1) / 2), 1'b0});
        end

        // reset mid-run then replay
        do_reset();
        go(0, 11);
        tick(5);
        do_reset();
        go(0, 11);
        for (int k = 0; k < 11; k++) begin
            tick();
            chk("t6_replay", {v_a[0], rd_a[0]}, {1'b1, 32'h2008_0001 + 32'(k)});
        end

        // zero-length program
        do_reset();
        go(0, 0);
        chk("t7_e1", {d_a[0], v_a[0]}, 64'd0);
        tick();
        chk("t7_e2", {d_a[0], v_a[0]}, 64'd2);
        repeat (3) begin
            tick();
            chk("t7_novalid", {63'd0, v_a[0]}, 64'd0);
        end

        // randomized runs
        for (int t = 0; t < 20; t++) begin
            do_reset();
            go(1'($urandom), $urandom_range(0, 20));
            repeat (45) begin
                Stall = ($urandom % 4) == 0;
                PCF = $urandom;
                LoadEn = ($urandom % 8) == 0;
                LoadAddr = AW'($urandom);
                LoadData = $urandom;
                Start = ($urandom % 12) == 0;
                AddrMode = 1'($urandom);
                ProgLen = (AW + 1)'($urandom_range(0, 20));
                tick();
            end
            Stall = 1'b0;
            LoadEn = 1'b0;
            Start = 1'b0;
        end

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
